if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
// - Instruction-fetch stage: owns PC, requests instruction words from instruction memory, presents {nxt_pc, inst} to if_id.
// - Sits between hazard/branch logic (pc_write, redirects) and the IF/ID register; outputs map 1:1 to if_id nxt_pc/inst_in.
// - Imem has variable latency (req/ack), so fetch is a small FSM rather than a bare PC register.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset
// - NOP_INST  32'h0000_0000  instruction word presented on bubbles/flush (sll $0,$0,0)
// PORTS
// - clock          in   1   single clock, rising edge
// - reset          in   1   asynchronous, active-high
// - pc_write       in   1   hazard unit: 1 = IF/ID consumes current fetch, advance PC
// - flush          in   1   squash current fetch output (inst_out <= NOP_INST)
// - branch_taken   in   1   redirect to branch_target
// - branch_target  in   32  word-aligned branch target
// - jump           in   1   redirect to {pc_plus4[31:28], jump_target, 2'b00}
// - jump_target    in   26  J-type target field
// - imem_req       out  1   registered read request
// - imem_addr      out  32  read address (= pc)
// - imem_rdata     in   32  read data, valid when imem_ack
// - imem_ack       in   1   one-cycle completion strobe for outstanding req
// - nxt_pc         out  32  pc+4 of presented instruction (to if_id nxt_pc)
// - inst_out       out  32  presented instruction (to if_id inst_in)
// - fetch_valid    out  1   inst_out holds a real fetched instruction
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, state=IDLE, imem_req=0, nxt_pc=0, inst_out=NOP_INST, fetch_valid=0, redir_pend=0.
// - States: IDLE -> WAIT (unconditional, next edge; imem_req<=1).
//   WAIT: hold imem_req=1, imem_addr=pc until imem_ack.
//     ack & !redir_pend: inst_out<=imem_rdata, nxt_pc<=pc+4, fetch_valid<=1, imem_req<=0 -> READY.
//     ack & redir_pend: drop data, redir_pend<=0, imem_req stays 1 (new pc) -> WAIT.
//   READY: outputs held while pc_write=0. pc_write=1: pc<=next_pc, inst_out<=NOP_INST, fetch_valid<=0, imem_req<=1 -> WAIT.
// - next_pc priority: jump > branch_taken > pc+4. jump uses pc+4 of the instruction in IF.
// - Redirect (jump|branch_taken) while in WAIT: pc<=target immediately, redir_pend<=1 unless imem_ack same cycle
//   (then data dropped, new request issued next cycle, redir_pend stays 0).
// - Redirects ignored in READY unless pc_write=1 (hazard unit holds them until stall clears).
// - flush=1: inst_out<=NOP_INST, fetch_valid<=0 same edge; in READY also moves to WAIT without advancing pc unless pc_write/redirect.
// - Simultaneous flush+redirect: both apply; flush never blocks the redirect.
// - Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). pc[1:0] forced 0; target low bits ignored.
// - Latency: min 2 cycles req->READY with zero-wait imem (ack in req cycle); one instruction in flight max.
// - Reset mid-WAIT: request abandoned; a late imem_ack after reset with imem_req=0 is ignored.
// STRUCTURE
// - Shared include mips_defs.vh: NOP_INST, RESET_PC defaults, fetch FSM state encodings (IDLE/WAIT/READY, 2 bits).
// - One sub-module: pc_next_mux (combinational: pc+4, jump concat, priority select).
// - Top: pc register, FSM, output registers, redir_pend flag.
// TESTING
// - Reset then zero-wait imem (ack in req cycle), pc_write=1: addresses 0,4,8,C; nxt_pc 4,8,C,10; fetch_valid pulses.
// - 3-cycle imem latency: inst_out=NOP_INST, fetch_valid=0 during wait; data captured only on ack.
// - pc_write=0 in READY for 4 cycles: inst_out, nxt_pc, imem_req=0 stable; advance on release.
// - jump_target=26'h0000010 at pc=0x1000_0000 with pc_write=1: next imem_addr=0x1000_0040; branch+jump same cycle -> jump wins.
// - branch_taken to 0x200 while WAIT (ack 2 cycles later): stale data dropped, fetch_valid stays 0, next ack from 0x200 captured.
// - pc=0xFFFF_FFFC fetch: nxt_pc=0; async reset asserted mid-WAIT: all outputs reset same cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: default reset PC and
// bubble instruction, fetch FSM state encoding, and a word-alignment helper.
// No ports.
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;   // sll $0,$0,0
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READY = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_next_mux.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pc_next_mux
// Combinational next-PC selection for the fetch stage.
//   i_pc            current fetch PC
//   i_branch_taken  branch redirect request
//   i_branch_target branch destination (low two bits ignored)
//   i_jump          jump redirect request (wins over branch)
//   i_jump_target   J-type 26-bit target field
//   o_pc_plus4      i_pc + 4, modulo 2^32
//   o_redir_target  redirect destination (jump if i_jump, else branch)
//   o_next_pc       redirect destination if any redirect, else pc+4
//   o_redirect      any redirect requested
// ----------------------------------------------------------------------------
module if_fetch_unit_pc_next_mux
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_target,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_redir_target,
    output logic [31:0] o_next_pc,
    output logic        o_redirect
);

    logic [31:0] w_jump_addr;

    assign o_pc_plus4  = i_pc + PC_STEP;
    // Jump region comes from pc+4 of the instruction in IF, not from pc itself.
    assign w_jump_addr = {o_pc_plus4[31:28], i_jump_target, 2'b00};

    always_comb begin
        o_redir_target = word_align(i_branch_target);
        if (i_jump) begin
            o_redir_target = w_jump_addr;
        end
    end

    assign o_redirect = i_jump | i_branch_taken;
    assign o_next_pc  = o_redirect ? o_redir_target : o_pc_plus4;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory (req/ack), and presents {nxt_pc, inst}
// to the IF/ID register.
//   i_clock, i_reset   clock (rising edge), async active-high reset
//   i_pc_write         IF/ID consumes the presented instruction; advance PC
//   i_flush            squash presented instruction (bubble)
//   i_branch_taken/i_branch_target   branch redirect
//   i_jump/i_jump_target             jump redirect (priority over branch)
//   o_imem_req/o_imem_addr           registered request, address = pc
//   i_imem_rdata/i_imem_ack          read data, one-cycle completion strobe
//   o_nxt_pc/o_inst_out              pc+4 and instruction presented to IF/ID
//   o_fetch_valid                    o_inst_out holds a real fetched word
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | after reset; issues first request on the next edge
// ST_WAIT  | request outstanding at pc; waiting for imem ack
// ST_READY | instruction presented; held until pc_write or flush
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pc_write,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ack,
    output logic [31:0] o_nxt_pc,
    output logic [31:0] o_inst_out,
    output logic        o_fetch_valid
);

    localparam logic [31:0] RESET_PC_AL = word_align(RESET_PC);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_nxt_pc;
    logic [31:0]  r_inst;
    logic         r_imem_req;
    logic         r_fetch_valid;
    logic         r_redir_pend;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redir_target;
    logic [31:0]  w_next_pc;
    logic         w_redirect;

    if_fetch_unit_pc_next_mux u_pc_next_mux (
        .i_pc            (r_pc),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_pc_plus4      (w_pc_plus4),
        .o_redir_target  (w_redir_target),
        .o_next_pc       (w_next_pc),
        .o_redirect      (w_redirect)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC_AL;
            r_nxt_pc      <= 32'h0000_0000;
            r_inst        <= NOP_INST;
            r_imem_req    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_redir_pend  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_WAIT;
                    r_imem_req <= 1'b1;
                end

                ST_WAIT: begin
                    if (w_redirect) begin
                        // Retarget now. If the old request completes this same
                        // cycle its data is simply dropped and nothing is left
                        // in flight; otherwise its ack must be discarded later.
                        r_pc         <= w_redir_target;
                        r_redir_pend <= ~i_imem_ack;
                    end else if (i_imem_ack) begin
                        if (r_redir_pend) begin
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_inst        <= i_imem_rdata;
                            r_nxt_pc      <= w_pc_plus4;
                            r_fetch_valid <= 1'b1;
                            r_imem_req    <= 1'b0;
                            r_state       <= ST_READY;
                        end
                    end
                    if (i_flush) begin
                        r_inst        <= NOP_INST;
                        r_fetch_valid <= 1'b0;
                    end
                end

                ST_READY: begin
                    if (i_pc_write) begin
                        r_pc          <= w_next_pc;
                        r_inst        <= NOP_INST;
                        r_fetch_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_WAIT;
                    end else if (i_flush) begin
                        // Refetch the same pc unless a redirect rides along.
                        if (w_redirect) begin
                            r_pc <= w_redir_target;
                        end
                        r_inst        <= NOP_INST;
                        r_fetch_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= ST_WAIT;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_nxt_pc      = r_nxt_pc;
    assign o_inst_out    = r_inst;
    assign o_fetch_valid = r_fetch_valid;

endmodule
